// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: CH PWM outputs driven from one shared period counter; debounced push-buttons step the selected channel's duty.
// Latency: outputs are combinational from registered counter/duties; a press reaches the shadow duty 2+DB_CYCLES..3+DB_CYCLES cycles after the pin edge and the pin at the next wrap.
// Backpressure: none; free-running counter, en=0 freezes the counter and forces every pwm low.
module pwm_multi_gen #(
    parameter int CH        = 4,
    parameter int CW        = 8,
    parameter int PERIOD    = 50,
    parameter int STEP      = 5,
    parameter int DB_CYCLES = 4,
    localparam int SW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clkin,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    input  logic [SW-1:0] ch_sel,
    input  logic          en,
    output logic [CH-1:0] pwm,
    output logic [CW-1:0] d,
    output logic          period_end
);
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    // Button path, index 0 = inc, index 1 = dec.
    logic [1:0]     btn;
    logic [1:0]     s1_q, s1_d;
    logic [1:0]     s2_q, s2_d;
    logic [1:0]     db_q, db_d;
    logic [1:0]     arm_q, arm_d;
    logic [1:0]     vld_q, vld_d;
    logic [1:0]     press;
    logic [DBW-1:0] dbc_q [2];
    logic [DBW-1:0] dbc_d [2];

    // Counter and duty state.
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  shadow_q [CH];
    logic [CW-1:0]  shadow_d [CH];
    logic [CW-1:0]  act_q [CH];
    logic [CW-1:0]  act_d [CH];
    logic           sel_ok;
    logic           wrap;

    assign btn        = {dec, inc};
    assign sel_ok     = ({1'b0, ch_sel} < (SW+1)'(CH));
    assign wrap       = en & (cnt_q == CW'(PERIOD - 1));
    assign period_end = wrap;

    // Saturating add, done one bit wider so the sum can never wrap.
    function automatic logic [CW-1:0] step_up(input logic [CW-1:0] v);
        logic [CW:0] s;
        s = {1'b0, v} + (CW+1)'(STEP);
        return (s > (CW+1)'(PERIOD)) ? CW'(PERIOD) : s[CW-1:0];
    endfunction

    // Saturating subtract; the extra top bit is the borrow.
    function automatic logic [CW-1:0] step_dn(input logic [CW-1:0] v);
        logic [CW:0] s;
        s = {1'b0, v} - (CW+1)'(STEP);
        return s[CW] ? '0 : s[CW-1:0];
    endfunction

    // Synchronise, debounce and detect debounced presses. A button only arms once it
    // has been seen released through the synchroniser, so one held across reset is ignored.
    always_comb begin
        s1_d  = btn;
        s2_d  = s1_q;
        vld_d = {vld_q[0], 1'b1};
        arm_d = arm_q | (s2_q & {2{vld_q[1]}});
        db_d  = db_q;
        press = '0;
        for (int b = 0; b < 2; b++) begin
            dbc_d[b] = '0;
            if (s2_q[b] != db_q[b]) begin
                if (dbc_q[b] == DBW'(DB_CYCLES - 1)) begin
                    db_d[b]  = s2_q[b];
                    press[b] = db_q[b] & arm_q[b];
                end else begin
                    dbc_d[b] = dbc_q[b] + DBW'(1);
                end
            end
        end
    end

    // Period counter, shadow duty stepping, and boundary-aligned transfer to the active duty.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
        for (int i = 0; i < CH; i++) begin
            shadow_d[i] = shadow_q[i];
            act_d[i]    = (wrap || !en) ? shadow_q[i] : act_q[i];
            if (sel_ok && (ch_sel == SW'(i)) && (press[0] ^ press[1])) begin
                shadow_d[i] = press[0] ? step_up(shadow_q[i]) : step_dn(shadow_q[i]);
            end
        end
    end

    // PWM compare per channel and the display mux of the selected active duty.
    always_comb begin
        pwm = '0;
        d   = '0;
        for (int i = 0; i < CH; i++) begin
            pwm[i] = en & (cnt_q < act_q[i]);
            if (sel_ok && (ch_sel == SW'(i))) begin
                d = act_q[i];
            end
        end
    end

    // State registers; buttons reset to the released level.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            s1_q     <= '1;
            s2_q     <= '1;
            db_q     <= '1;
            arm_q    <= '0;
            vld_q    <= '0;
            dbc_q[0] <= '0;
            dbc_q[1] <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                shadow_q[i] <= '0;
                act_q[i]    <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            db_q     <= db_d;
            arm_q    <= arm_d;
            vld_q    <= vld_d;
            dbc_q[0] <= dbc_d[0];
            dbc_q[1] <= dbc_d[1];
            cnt_q    <= cnt_d;
            for (int i = 0; i < CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                act_q[i]    <= act_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed plus randomized stimulus for pwm_multi_gen against a cycle reference model.
// Latency: outputs compared on every falling edge, after the rising-edge update.
// Backpressure: none; the bench drives inputs on falling edges only.
module tb_pwm_multi_gen;
    localparam int CH     = 4;
    localparam int CW     = 8;
    localparam int PERIOD = 50;
    localparam int STEP   = 5;
    localparam int DB     = 4;

    logic          clkin = 1'b0;
    logic          reset;
    logic          inc;
    logic          dec;
    logic [1:0]    ch_sel;
    logic          en;
    logic [CH-1:0] pwm;
    logic [CW-1:0] d;
    logic          period_end;

    always #5 clkin = ~clkin;

    pwm_multi_gen #(
        .CH(CH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP), .DB_CYCLES(DB)
    ) dut (
        .clkin(clkin), .reset(reset), .inc(inc), .dec(dec), .ch_sel(ch_sel),
        .en(en), .pwm(pwm), .d(d), .period_end(period_end)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: counter value, duties, debounced level and raw pin history.
    int m_cnt;
    int m_edges;
    int m_sh  [CH];
    int m_act [CH];
    bit m_db  [2];
    bit m_arm [2];
    bit hist  [2][DB+3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_edges = 0;
        for (int i = 0; i < CH; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        for (int b = 0; b < 2; b++) begin
            m_db[b]  = 1'b1;
            m_arm[b] = 1'b0;
            for (int j = 0; j < DB + 3; j++) hist[b][j] = 1'b1;
        end
    endtask

    // One rising edge of the model. hist[b][n] is the pin level sampled n edges ago;
    // the synchroniser makes the debouncer see samples 2..DB+1 edges old.
    task automatic model_update();
        bit btn [2];
        bit ev  [2];
        bit all_diff;
        int old_sh [CH];
        btn[0] = inc;
        btn[1] = dec;
        if (m_edges < 1000) m_edges++;
        for (int b = 0; b < 2; b++) begin
            for (int j = DB + 2; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = btn[b];
            if (m_edges >= 4 && hist[b][3]) m_arm[b] = 1'b1;
            all_diff = 1'b1;
            for (int t = 2; t <= DB + 1; t++) if (hist[b][t] == m_db[b]) all_diff = 1'b0;
            ev[b] = 1'b0;
            if (all_diff) begin
                ev[b]   = m_db[b] & m_arm[b];
                m_db[b] = ~m_db[b];
            end
        end
        old_sh = m_sh;
        if (ev[0] != ev[1] && int'(ch_sel) < CH) begin
            if (ev[0]) m_sh[ch_sel] = (m_sh[ch_sel] + STEP > PERIOD) ? PERIOD : m_sh[ch_sel] + STEP;
            else       m_sh[ch_sel] = (m_sh[ch_sel] < STEP) ? 0 : m_sh[ch_sel] - STEP;
        end
        if (!en || m_cnt == PERIOD - 1) m_act = old_sh;
        if (en) m_cnt = (m_cnt + 1) % PERIOD;
    endtask

    task automatic check_all();
        logic [CH-1:0] ep;
        logic [CW-1:0] ed;
        ep = '0;
        ed = '0;
        for (int i = 0; i < CH; i++) ep[i] = en && (m_cnt < m_act[i]);
        if (int'(ch_sel) < CH) ed = CW'(m_act[ch_sel]);
        check("pwm", 32'(pwm), 32'(ep));
        check("d", 32'(d), 32'(ed));
        check("period_end", 32'(period_end), 32'(en && m_cnt == PERIOD - 1));
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clkin);
            if (reset) model_update();
            @(negedge clkin);
            check_all();
        end
    endtask

    task automatic press(input bit pi, input bit pd);
        inc = ~pi;
        dec = ~pd;
        cycle(DB + 3 + $urandom_range(0, 3));
        inc = 1'b1;
        dec = 1'b1;
        cycle(DB + 3 + $urandom_range(0, 3));
    endtask

    task automatic wait_cnt(input int v);
        for (int k = 0; k < 2 * PERIOD && m_cnt != v; k++) cycle(1);
    endtask

    int pulses;
    int hi;
    int other;
    int k;

    initial begin
        reset = 1'b0; inc = 1'b1; dec = 1'b1; en = 1'b1; ch_sel = '0;
        model_reset();
        cycle(3);
        check("rst_pwm", 32'(pwm), 0);
        check("rst_d", 32'(d), 0);
        check("rst_period_end", 32'(period_end), 0);
        reset = 1'b1;

        // Idle: period_end every PERIOD cycles, no pwm activity.
        pulses = 0; hi = 0;
        repeat (200) begin cycle(1); pulses += int'(period_end); hi += int'(|pwm); end
        check("idle_pulses", pulses, 4);
        check("idle_pwm_high", hi, 0);

        // Three increments on channel 1.
        ch_sel = 2'd1;
        repeat (3) press(1'b1, 1'b0);
        cycle(PERIOD + 2);
        check("ch1_d", 32'(d), 15);
        hi = 0; other = 0;
        repeat (PERIOD) begin cycle(1); hi += int'(pwm[1]); other += int'(pwm[0] | pwm[2] | pwm[3]); end
        check("ch1_high_cycles", hi, 15);
        check("ch1_others", other, 0);

        // Saturation at PERIOD then at zero on channel 2.
        ch_sel = 2'd2;
        repeat (12) press(1'b1, 1'b0);
        cycle(PERIOD + 2);
        check("ch2_sat_hi_d", 32'(d), PERIOD);
        hi = 0;
        repeat (PERIOD) begin cycle(1); hi += int'(pwm[2]); end
        check("ch2_sat_hi_pwm", hi, PERIOD);
        repeat (12) press(1'b0, 1'b1);
        cycle(PERIOD + 2);
        check("ch2_sat_lo_d", 32'(d), 0);
        hi = 0;
        repeat (PERIOD) begin cycle(1); hi += int'(pwm[2]); end
        check("ch2_sat_lo_pwm", hi, 0);

        // Bouncing press gives exactly one step; a short glitch gives none.
        ch_sel = 2'd3;
        repeat (5) begin inc = 1'b0; cycle(2); inc = 1'b1; cycle(2); end
        inc = 1'b0; cycle(DB + 6); inc = 1'b1; cycle(DB + 6);
        cycle(PERIOD + 2);
        check("bounce_d", 32'(d), 5);
        inc = 1'b0; cycle(DB - 1); inc = 1'b1;
        cycle(PERIOD + 10);
        check("glitch_d", 32'(d), 5);

        // Simultaneous inc and dec: no change.
        press(1'b1, 1'b1);
        cycle(PERIOD + 2);
        check("both_d", 32'(d), 5);

        // Mid-period press only takes effect at the next wrap.
        wait_cnt(20);
        press(1'b1, 1'b0);
        check("mid_before_wrap_d", 32'(d), 5);
        cycle(PERIOD);
        check("mid_after_wrap_d", 32'(d), 10);

        // Load duties {10,20,30,40}.
        ch_sel = 2'd0; repeat (2) press(1'b1, 1'b0);
        ch_sel = 2'd1; press(1'b1, 1'b0);
        ch_sel = 2'd2; repeat (6) press(1'b1, 1'b0);
        ch_sel = 2'd3; repeat (6) press(1'b1, 1'b0);
        cycle(PERIOD + 5);
        for (int i = 0; i < CH; i++) begin
            ch_sel = 2'(i);
            #1;
            check("duty_load", 32'(d), 10 * (i + 1));
        end
        ch_sel = 2'd3;

        // Reset mid-period with inc held low across its release.
        wait_cnt(25);
        check("pre_reset_pwm", 32'(pwm), 32'b1100);
        inc = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_pwm", 32'(pwm), 0);
        check("async_rst_d", 32'(d), 0);
        check("async_rst_period_end", 32'(period_end), 0);
        cycle(1);
        reset = 1'b1;
        cycle(20);
        inc = 1'b1;
        cycle(DB + 6);
        cycle(PERIOD + 5);
        check("held_through_reset_d", 32'(d), 0);
        press(1'b1, 1'b0);
        cycle(PERIOD + 5);
        check("after_reset_press_d", 32'(d), 5);

        // Disable for 30 cycles; duty follows shadow immediately; counter resumes from 30.
        wait_cnt(30);
        en = 1'b0;
        hi = 0; pulses = 0;
        for (int j = 0; j < 30; j++) begin
            if (j == 0) inc = 1'b0;
            if (j == 7) inc = 1'b1;
            cycle(1);
            hi += int'(|pwm);
            pulses += int'(period_end);
        end
        check("en0_pwm_high", hi, 0);
        check("en0_period_end", pulses, 0);
        check("en0_d_immediate", 32'(d), 10);
        en = 1'b1;
        k = 0;
        while (!period_end && k < 100) begin cycle(1); k++; end
        check("resume_cycles_to_wrap", k, PERIOD - 1 - 30);

        // Randomized phase against the model.
        repeat (30) begin
            ch_sel = 2'($urandom_range(0, CH - 1));
            case ($urandom_range(0, 4))
                0: press(1'b1, 1'b0);
                1: press(1'b0, 1'b1);
                2: press(1'b1, 1'b1);
                3: begin inc = 1'b0; cycle($urandom_range(1, DB + 2)); inc = 1'b1; cycle(DB + 3); end
                default: begin en = ~en; cycle($urandom_range(5, 40)); end
            endcase
        end
        en = 1'b1;
        cycle(PERIOD + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
